// File: rtl/bounce_box_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bounce_box_ctrl
// Description : Moves a square box around the active video area once per
//               accepted frame tick, reflecting off the walls. One shared
//               11-bit add/subtract unit serves both axes: x in CALC_X, then
//               y in CALC_Y. Both coordinates and directions commit together
//               in COMMIT, so the outputs are never partially updated.
// Ports       : clk        - single clock, rising edge
//               rst        - synchronous active-high reset
//               frame_tick - one-cycle pulse at start of vertical blanking
//               pause      - blocks acceptance of frame_tick while high
//               speed[2:0] - step in pixels per frame (0 = frozen)
//               box_x/box_y[9:0] - committed top-left position
//               dir_x/dir_y      - 1 = moving right / down
//               bounce     - one-cycle pulse when any wall is hit
//               corner     - one-cycle pulse when both axes hit together
//               busy       - update in progress (state != IDLE)
//               overrun    - sticky: a frame_tick arrived while busy
// Revision    : 1.0 - initial release
// ============================================================================
module bounce_box_ctrl #(
  parameter int H_MAX = 640,
  parameter int V_MAX = 480,
  parameter int BOX   = 32,
  parameter int X0    = 304,
  parameter int Y0    = 224
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       pause,
  input  logic [2:0] speed,
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic       bounce,
  output logic       corner,
  output logic       busy,
  output logic       overrun
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC_X = 2'd1;
  localparam logic [1:0] S_CALC_Y = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  localparam logic [10:0] C_LIM_X = 11'(H_MAX - BOX);
  localparam logic [10:0] C_LIM_Y = 11'(V_MAX - BOX);
  localparam logic [9:0]  C_X0    = 10'(X0);
  localparam logic [9:0]  C_Y0    = 10'(Y0);

  logic [1:0] r_state;
  logic [2:0] r_speed;      // speed captured at tick acceptance
  logic [9:0] r_shadow_x;
  logic [9:0] r_shadow_y;
  logic       r_ndir_x;
  logic       r_ndir_y;
  logic       r_hit_x;
  logic       r_hit_y;

  // Shared arithmetic: operand selection follows the calculation state.
  logic        w_on_x;
  logic [9:0]  w_pos;
  logic        w_dir;
  logic [10:0] w_lim;
  logic [10:0] w_step;
  logic [10:0] w_sum;
  logic        w_at_wall;
  logic [9:0]  w_next_pos;
  logic        w_next_dir;

  always_comb begin
    w_on_x = (r_state == S_CALC_X);
    w_pos  = w_on_x ? box_x   : box_y;
    w_dir  = w_on_x ? dir_x   : dir_y;
    w_lim  = w_on_x ? C_LIM_X : C_LIM_Y;
    w_step = {8'd0, r_speed};
    // 11-bit sum: the carry/borrow bit keeps the wall compare free of wrap.
    w_sum  = w_dir ? ({1'b0, w_pos} + w_step) : ({1'b0, w_pos} - w_step);
    // Moving down/right clamps at LIMIT; moving up/left clamps at 0. The
    // unsigned pos <= step compare catches underflow before it happens.
    w_at_wall  = w_dir ? (w_sum >= w_lim) : ({1'b0, w_pos} <= w_step);
    w_next_pos = w_at_wall ? (w_dir ? w_lim[9:0] : 10'd0) : w_sum[9:0];
    w_next_dir = w_at_wall ? ~w_dir : w_dir;
  end

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_speed    <= 3'd0;
      r_shadow_x <= 10'd0;
      r_shadow_y <= 10'd0;
      r_ndir_x   <= 1'b0;
      r_ndir_y   <= 1'b0;
      r_hit_x    <= 1'b0;
      r_hit_y    <= 1'b0;
      box_x      <= C_X0;
      box_y      <= C_Y0;
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
      bounce     <= 1'b0;
      corner     <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      bounce <= 1'b0;
      corner <= 1'b0;
      // Ticks that land mid-update are dropped and remembered.
      if (frame_tick && (r_state != S_IDLE)) begin
        overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (frame_tick && !pause) begin
            r_speed <= speed;
            r_state <= S_CALC_X;
          end
        end
        S_CALC_X: begin
          r_shadow_x <= w_next_pos;
          r_ndir_x   <= w_next_dir;
          r_hit_x    <= w_at_wall;
          r_state    <= S_CALC_Y;
        end
        S_CALC_Y: begin
          r_shadow_y <= w_next_pos;
          r_ndir_y   <= w_next_dir;
          r_hit_y    <= w_at_wall;
          r_state    <= S_COMMIT;
        end
        default: begin // S_COMMIT
          box_x   <= r_shadow_x;
          box_y   <= r_shadow_y;
          dir_x   <= r_ndir_x;
          dir_y   <= r_ndir_y;
          bounce  <= r_hit_x | r_hit_y;
          corner  <= r_hit_x & r_hit_y;
          r_hit_x <= 1'b0;
          r_hit_y <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bounce_box_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bounce_box_ctrl
// Description : Scoreboard bench for bounce_box_ctrl. Two instances: the
//               default-parameter block and a small 232x232 arena starting
//               at (100,100). Stimulus pushes expected outputs into a queue;
//               a monitor pops and compares on every completed update
//               (busy falling) or on an explicit probe request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bounce_box_ctrl;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       dx;
    logic       dy;
    logic       b;
    logic       c;
    logic       ov;
    int         blen;   // expected busy length, -1 = not checked
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_a;
  logic       tick_b;
  logic       pause;
  logic [2:0] speed;

  logic [9:0] a_x, a_y, b_x, b_y;
  logic       a_dx, a_dy, a_bn, a_cn, a_busy, a_ov;
  logic       b_dx, b_dy, b_bn, b_cn, b_busy, b_ov;

  bit   sel   = 1'b0;   // 0 = default instance, 1 = small arena instance
  bit   probe = 1'b0;
  bit   fin   = 1'b0;
  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // model state
  int   mx, my, lim_x, lim_y;
  logic mdx, mdy, mov;

  always #5 clk = ~clk;

  bounce_box_ctrl u_dut_a (
    .clk(clk), .rst(rst), .frame_tick(tick_a), .pause(pause), .speed(speed),
    .box_x(a_x), .box_y(a_y), .dir_x(a_dx), .dir_y(a_dy),
    .bounce(a_bn), .corner(a_cn), .busy(a_busy), .overrun(a_ov)
  );

  bounce_box_ctrl #(
    .H_MAX(232), .V_MAX(232), .BOX(32), .X0(100), .Y0(100)
  ) u_dut_b (
    .clk(clk), .rst(rst), .frame_tick(tick_b), .pause(pause), .speed(speed),
    .box_x(b_x), .box_y(b_y), .dir_x(b_dx), .dir_y(b_dy),
    .bounce(b_bn), .corner(b_cn), .busy(b_busy), .overrun(b_ov)
  );

  // ---------------------------------------------------------------- monitor
  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic prev_busy = 1'b0;
  int   run_len   = 0;
  bit   fin_done  = 1'b0;

  always @(negedge clk) begin
    logic [9:0] cx, cy;
    logic cdx, cdy, cbn, ccn, cbusy, cov;
    exp_t e;
    cx    = sel ? b_x    : a_x;
    cy    = sel ? b_y    : a_y;
    cdx   = sel ? b_dx   : a_dx;
    cdy   = sel ? b_dy   : a_dy;
    cbn   = sel ? b_bn   : a_bn;
    ccn   = sel ? b_cn   : a_cn;
    cbusy = sel ? b_busy : a_busy;
    cov   = sel ? b_ov   : a_ov;
    if ((prev_busy && !cbusy) || probe) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_output: got update/probe, expected none (t=%0t)", $time);
      end else begin
        e = q.pop_front();
        chk("box_x",   int'(cx),    int'(e.x));
        chk("box_y",   int'(cy),    int'(e.y));
        chk("dir_x",   int'(cdx),   int'(e.dx));
        chk("dir_y",   int'(cdy),   int'(e.dy));
        chk("bounce",  int'(cbn),   int'(e.b));
        chk("corner",  int'(ccn),   int'(e.c));
        chk("overrun", int'(cov),   int'(e.ov));
        chk("busy",    int'(cbusy), 0);
        if (e.blen >= 0) chk("busy_len", run_len, e.blen);
      end
    end else begin
      // Outside a commit cycle the pulses must stay low.
      chk("idle_pulse", int'({cbn, ccn}), 0);
    end
    if (fin && !fin_done) begin
      fin_done = 1'b1;
      chk("queue_left", q.size(), 0);
    end
    run_len   = cbusy ? run_len + 1 : 0;
    prev_busy = cbusy;
  end

  // --------------------------------------------------------------- stimulus
  task automatic axis(input int lim, input int s, input int p, input logic d,
                      output int np, output logic nd, output logic hit);
    hit = 1'b0;
    nd  = d;
    if (d) begin
      np = p + s;
      if (np >= lim) begin np = lim; nd = 1'b0; hit = 1'b1; end
    end else if (p <= s) begin
      np = 0; nd = 1'b1; hit = 1'b1;
    end else begin
      np = p - s;
    end
  endtask

  task automatic model_reset();
    mx    = sel ? 100 : 304;
    my    = sel ? 100 : 224;
    lim_x = sel ? 200 : 608;
    lim_y = sel ? 200 : 448;
    mdx   = 1'b1;
    mdy   = 1'b1;
    mov   = 1'b0;
  endtask

  task automatic push_model(input logic hx, input logic hy, input int blen);
    exp_t e;
    e = '{x: 10'(mx), y: 10'(my), dx: mdx, dy: mdy, b: hx | hy, c: hx & hy,
          ov: mov, blen: blen};
    q.push_back(e);
  endtask

  task automatic model_step(output logic hx, output logic hy);
    int n;
    logic d;
    axis(lim_x, int'(speed), mx, mdx, n, d, hx); mx = n; mdx = d;
    axis(lim_y, int'(speed), my, mdy, n, d, hy); my = n; mdy = d;
  endtask

  task automatic set_tick(input logic v);
    if (sel) tick_b = v; else tick_a = v;
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic do_tick(input bit disturb);
    logic hx, hy;
    logic [2:0] sv;
    sv = speed;
    model_step(hx, hy);
    push_model(hx, hy, 3);
    set_tick(1'b1);
    @(posedge clk); #1;                    // E0 accepted
    set_tick(1'b0);
    if (disturb) begin speed = speed + 3'd3; pause = 1'b1; end
    repeat (3) @(posedge clk); #1;         // E3 committed
    if (disturb) begin speed = sv; pause = 1'b0; end
    @(posedge clk); #1;
  endtask

  task automatic do_probe(input int x, input int y, input logic dx,
                          input logic dy, input logic ov);
    exp_t e;
    e = '{x: 10'(x), y: 10'(y), dx: dx, dy: dy, b: 1'b0, c: 1'b0, ov: ov, blen: -1};
    q.push_back(e);
    probe = 1'b1;
    @(posedge clk); #1;
    probe = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1; tick_a = 1'b0; tick_b = 1'b0; pause = 1'b0; speed = 3'd0;
    @(posedge clk); #1;
    do_reset();
    do_probe(304, 224, 1'b1, 1'b1, 1'b0);          // reset state

    speed = 3'd4;
    do_tick(1'b0);
    do_probe(308, 228, 1'b1, 1'b1, 1'b0);          // first step

    pause = 1'b1;                                  // paused tick ignored
    tick_a = 1'b1; @(posedge clk); #1; tick_a = 1'b0;
    repeat (5) @(posedge clk); #1;
    pause = 1'b0;
    do_probe(308, 228, 1'b1, 1'b1, 1'b0);

    do_tick(1'b1);                                 // speed/pause disturbed mid-update
    do_probe(312, 232, 1'b1, 1'b1, 1'b0);

    speed = 3'd0;                                  // frozen update
    do_tick(1'b0);
    do_probe(312, 232, 1'b1, 1'b1, 1'b0);
    speed = 3'd4;

    // reset during CALC_Y aborts the update
    q.push_back('{x: 10'd304, y: 10'd224, dx: 1'b1, dy: 1'b1, b: 1'b0, c: 1'b0,
                  ov: 1'b0, blen: -1});
    tick_a = 1'b1; @(posedge clk); #1;             // E0
    tick_a = 1'b0; @(posedge clk); #1;             // E1: now CALC_Y
    rst = 1'b1;    @(posedge clk); #1;             // E2: reset sampled
    rst = 1'b0;
    model_reset();
    repeat (4) @(posedge clk); #1;
    do_probe(304, 224, 1'b1, 1'b1, 1'b0);

    // two ticks close together: one update, sticky overrun
    mov = 1'b1;
    q.push_back('{x: 10'd308, y: 10'd228, dx: 1'b1, dy: 1'b1, b: 1'b0, c: 1'b0,
                  ov: 1'b1, blen: 3});
    mx = 308; my = 228;
    tick_a = 1'b1; @(posedge clk); #1;             // E0
    tick_a = 1'b0; @(posedge clk); #1;             // E1
    tick_a = 1'b1; @(posedge clk); #1;             // E2 (busy)
    tick_a = 1'b0; @(posedge clk); #1;             // E3
    @(posedge clk); #1;
    do_probe(308, 228, 1'b1, 1'b1, 1'b1);
    do_tick(1'b0);
    do_probe(312, 232, 1'b1, 1'b1, 1'b1);
    do_reset();
    do_probe(304, 224, 1'b1, 1'b1, 1'b0);

    // long run at speed 7: y wall at tick 32, x wall at tick 44
    speed = 3'd7;
    for (int i = 1; i <= 44; i++) begin
      do_tick(1'b0);
      if (i == 32) do_probe(528, 448, 1'b1, 1'b0, 1'b0);
    end
    do_probe(608, 364, 1'b0, 1'b0, 1'b0);

    // small arena: corner hit at tick 25
    sel = 1'b1;
    do_reset();
    do_probe(100, 100, 1'b1, 1'b1, 1'b0);
    speed = 3'd4;
    for (int i = 1; i <= 25; i++) do_tick(1'b0);
    do_probe(200, 200, 1'b0, 1'b0, 1'b0);
    do_tick(1'b0);
    do_probe(196, 196, 1'b0, 1'b0, 1'b0);

    fin = 1'b1;
    repeat (3) @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bounce_box_ctrl.md
BOUNCE_BOX_CTRL -- requirements
Module: bounce_box_ctrl

Interface
REQ-001 The block SHALL have parameter H_MAX, default 640, meaning the horizontal active width in pixels.
REQ-002 The block SHALL have parameter V_MAX, default 480, meaning the vertical active height in pixels.
REQ-003 The block SHALL have parameter BOX, default 32, meaning the box edge length in pixels.
REQ-004 The block SHALL have parameters X0 and Y0, defaults 304 and 224, meaning the reset position of the box's top-left corner.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port frame_tick, input, 1 bit: one-cycle pulse at the start of vertical blanking.
REQ-008 The block SHALL have port pause, input, 1 bit: while high, frame_tick is not accepted.
REQ-009 The block SHALL have port speed, input, 3 bits: step in pixels per frame (0-7); 0 means frozen.
REQ-010 The block SHALL have ports box_x and box_y, outputs, 10 bits each: committed box top-left position.
REQ-011 The block SHALL have ports dir_x and dir_y, outputs, 1 bit each: 1 means +x (right) or +y (down).
REQ-012 The block SHALL have port bounce, output, 1 bit: one-cycle pulse when a wall is hit.
REQ-013 The block SHALL have port corner, output, 1 bit: one-cycle pulse when both axes hit walls on the same update.
REQ-014 The block SHALL have port busy, output, 1 bit: high while an update is in progress.
REQ-015 The block SHALL have port overrun, output, 1 bit: sticky flag set when a frame_tick is dropped.

Function
REQ-016 The FSM SHALL have the states IDLE, CALC_X, CALC_Y and COMMIT, and one shared 11-bit add/subtract unit SHALL be used, for x in CALC_X and for y in CALC_Y.
REQ-017 In IDLE, frame_tick=1 with pause=0 SHALL register speed and move the FSM to CALC_X; CALC_X SHALL go to CALC_Y, then COMMIT, then IDLE, one cycle each.
REQ-018 busy SHALL equal (state != IDLE), so it is high for exactly 3 cycles per update.
REQ-019 Latency: for a tick sampled at edge E0, the new box_x, box_y, dir_x and dir_y SHALL become visible after edge E3, and bounce/corner SHALL be high only in the cycle following E3.
REQ-020 box_x and box_y SHALL change only in COMMIT, both on the same edge; they SHALL never be partially updated.
REQ-021 Moving +: if pos+speed >= LIMIT (LIMIT = H_MAX-BOX or V_MAX-BOX), the shadow position SHALL be LIMIT, the direction SHALL flip to 0, and the axis hit SHALL be set; otherwise the shadow position SHALL be pos+speed.
REQ-022 Moving -: if pos <= speed, the shadow position SHALL be 0, the direction SHALL flip to 1, and the axis hit SHALL be set; otherwise the shadow position SHALL be pos-speed.
REQ-023 Sums SHALL be computed at 11 bits, so there is no 10-bit wrap-around; positions SHALL never leave [0, LIMIT].
REQ-024 Direction flips SHALL commit together with the positions in COMMIT.
REQ-025 bounce SHALL equal hit_x OR hit_y, and corner SHALL equal hit_x AND hit_y; the hit flags SHALL be cleared on return to IDLE.
REQ-026 With speed=0, an update SHALL still run its full sequence and leave the position unchanged; a wall hit is still detected if pos is at a wall (LIMIT, or 0 with pos <= 0).
REQ-027 A frame_tick arriving while busy=1 SHALL be ignored and SHALL set overrun=1; overrun SHALL be cleared only by rst.
REQ-028 pause and speed changes during busy SHALL NOT affect the update in progress.
REQ-029 frame_tick with pause=1 in IDLE SHALL be ignored and SHALL NOT set overrun.

Reset
REQ-030 While rst=1, on every edge the block SHALL set state=IDLE, box_x=X0, box_y=Y0, dir_x=1, dir_y=1, and bounce=corner=busy=overrun=0, and SHALL clear the shadow and hit registers.
REQ-031 rst SHALL take priority over a frame_tick in the same cycle, and asserted in any state SHALL abort the update with no partial commit.

Verification
REQ-032 Defaults, reset, speed=4, one tick -> busy high for 3 cycles; after E3 box_x=308, box_y=228; bounce=0.
REQ-033 Defaults, speed=7, 44 ticks -> tick 32 gives box_y=448 and dir_y=0 with a bounce pulse; tick 44 gives box_x=608, dir_x=0, box_y=364, with a bounce pulse.
REQ-034 X0=Y0=100, H_MAX=V_MAX=232, speed=4, 25 ticks -> box_x=box_y=200, dir_x=dir_y=0, bounce=corner=1 for one cycle; tick 26 -> 196,196.
REQ-035 Two ticks 1 cycle apart, speed=4, from defaults -> one update only (box_x=308), overrun=1 and held until rst.
REQ-036 pause=1 plus a tick -> busy stays 0, positions unchanged, overrun=0.
REQ-037 rst asserted during CALC_Y -> the next cycle shows box_x=304, box_y=224, busy=0, and no bounce pulse.
